// File: rtl/cpu_host_pkg.sv
// Shared definitions for the host-side processor controller: command opcodes,
// controller FSM states and default width/depth constants.
package cpu_host_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_INSTR_W     = 16;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_IM_DEPTH    = 4096;
    localparam int DEF_DM_DEPTH    = 4096;
    localparam int DEF_WDOG_CYCLES = 65535;

    typedef enum logic [1:0] {
        OP_LOAD_IM = 2'd0,
        OP_LOAD_DM = 2'd1,
        OP_RUN     = 2'd2,
        OP_READ_DM = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_OUT
    } state_e;

endpackage

// File: rtl/cpu_host_ctrl_if.sv
// Host-facing bus of cpu_host_ctrl: command, load-data and readback
// handshakes plus the done/err/busy status lines.
// master = external host (UART/bus bridge), slave = controller.
interface cpu_host_ctrl_if #(
    parameter int ADDR_W  = cpu_host_pkg::DEF_ADDR_W,
    parameter int INSTR_W = cpu_host_pkg::DEF_INSTR_W,
    parameter int DATA_W  = cpu_host_pkg::DEF_DATA_W
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [ADDR_W-1:0]  cmd_len;

    logic               wr_valid;
    logic               wr_ready;
    logic [INSTR_W-1:0] wr_data;

    logic               rd_valid;
    logic               rd_ready;
    logic [DATA_W-1:0]  rd_data;

    logic               done;
    logic               err;
    logic               busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, err, busy
    );

endinterface

// File: rtl/host_range_check.sv
// Combinational bounds check for a burst: flags addr+len beyond the target
// memory depth. The sum is one bit wider than the address so it cannot wrap.
module host_range_check #(
    parameter int ADDR_W = cpu_host_pkg::DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [ADDR_W:0]   depth_i,
    output logic              over_o
);

    logic [ADDR_W:0] end_w;

    assign end_w  = {1'b0, addr_i} + {1'b0, len_i};
    assign over_o = (end_w > depth_i);

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host-side controller for the processor subsystem: sequences memory loads,
// processor runs and data-memory readback behind valid/ready handshakes.
// Optional run watchdog: define CPU_HOST_WDOG_EN to abort a RUN that sees no
// cpu_end within WDOG_CYCLES cycles (sets err).
module cpu_host_ctrl
    import cpu_host_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IM_DEPTH    = DEF_IM_DEPTH,
    parameter int DM_DEPTH    = DEF_DM_DEPTH,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    cpu_host_ctrl_if.slave     host,
    output logic               im_we,
    output logic               dm_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0]  dm_rdata,
    output logic               cpu_run,
    input  logic               cpu_end
);

    localparam int              AW1        = ADDR_W + 1;
    localparam logic [ADDR_W:0] IM_DEPTH_W = AW1'(IM_DEPTH);
    localparam logic [ADDR_W:0] DM_DEPTH_W = AW1'(DM_DEPTH);

    state_e              state_q;
    op_e                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                wr_ready_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                done_q;
    logic                err_q;
    logic                busy_q;
    logic                cpu_run_q;

    op_e                 cmd_op_d;
    logic [ADDR_W:0]     depth_d;
    logic                range_over_d;
    logic                wr_fire_d;
    logic                rd_fire_d;
    logic                last_d;

`ifdef CPU_HOST_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdog_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
`endif

    assign cmd_op_d  = op_e'(host.cmd_op);
    // Only LOAD_IM targets instruction memory; every other burst is DM-bound.
    assign depth_d   = (cmd_op_d == OP_LOAD_IM) ? IM_DEPTH_W : DM_DEPTH_W;
    assign wr_fire_d = wr_ready_q && host.wr_valid;
    assign rd_fire_d = rd_valid_q && host.rd_ready;
    assign last_d    = (cnt_q == ADDR_W'(1));

    host_range_check #(.ADDR_W(ADDR_W)) u_range (
        .addr_i (host.cmd_addr),
        .len_i  (host.cmd_len),
        .depth_i(depth_d),
        .over_o (range_over_d)
    );

    // cmd_ready is a pure state decode, gated by rst so it reads 0 during reset
    // and 1 as soon as reset is released.
    assign host.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign host.wr_ready  = wr_ready_q;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
    assign host.done      = done_q;
    assign host.err       = err_q;
    assign host.busy      = busy_q;
    assign cpu_run        = cpu_run_q;

    // Write strobes fire in the same cycle as the beat handshake; write data is
    // zeroed whenever no strobe is active.
    assign im_we     = wr_fire_d && (op_q == OP_LOAD_IM);
    assign dm_we     = wr_fire_d && (op_q == OP_LOAD_DM);
    assign mem_addr  = addr_q;
    assign mem_wdata = (im_we || dm_we) ? host.wr_data : '0;

    // Command sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_LOAD_IM;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cpu_run_q  <= 1'b0;
`ifdef CPU_HOST_WDOG_EN
            wdog_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (host.cmd_valid) begin
                        op_q   <= cmd_op_d;
                        addr_q <= host.cmd_addr;
                        cnt_q  <= host.cmd_len;
                        err_q  <= 1'b0;
                        if (cmd_op_d != OP_RUN && range_over_d) begin
                            // Out-of-range burst: report and stay idle, no memory access.
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (cmd_op_d != OP_RUN && host.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q <= 1'b1;
                            case (cmd_op_d)
                                OP_LOAD_IM, OP_LOAD_DM: begin
                                    state_q    <= ST_LOAD;
                                    wr_ready_q <= 1'b1;
                                end
                                OP_RUN: begin
                                    state_q   <= ST_RUN;
                                    cpu_run_q <= 1'b1;
`ifdef CPU_HOST_WDOG_EN
                                    wdog_q    <= '0;
`endif
                                end
                                default: begin
                                    state_q <= ST_RD_REQ;
                                end
                            endcase
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_fire_d) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        cnt_q  <= cnt_q - ADDR_W'(1);
                        if (last_d) begin
                            state_q    <= ST_IDLE;
                            wr_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cpu_end) begin
                        state_q   <= ST_IDLE;
                        cpu_run_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
`ifdef CPU_HOST_WDOG_EN
                    else if (wdog_q == WDOG_LAST) begin
                        state_q   <= ST_IDLE;
                        cpu_run_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
`endif
                end
                ST_RD_REQ: begin
                    // mem_addr already carries addr_q; the memory samples it this edge.
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rd_data_q  <= dm_rdata;
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (rd_fire_d) begin
                        rd_valid_q <= 1'b0;
                        addr_q     <= addr_q + ADDR_W'(1);
                        cnt_q      <= cnt_q - ADDR_W'(1);
                        if (last_d) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_REQ;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Self-checking bench for cpu_host_ctrl: directed scenarios plus randomized
// load/readback/run traffic checked against reference memory images.
module tb_cpu_host_ctrl;
    import cpu_host_pkg::*;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic im_we, dm_we, cpu_run;
    logic cpu_end = 1'b0;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic [DATA_W-1:0]  dm_rdata = '0;

    cpu_host_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) hif ();

    cpu_host_ctrl #(
        .DATA_W(DATA_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W),
        .IM_DEPTH(DEPTH), .DM_DEPTH(DEPTH), .WDOG_CYCLES(100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (hif.slave),
        .im_we    (im_we),
        .dm_we    (dm_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .dm_rdata (dm_rdata),
        .cpu_run  (cpu_run),
        .cpu_end  (cpu_end)
    );

    always #5 clk = ~clk;

    // Memories driven by the DUT strobes; DM read has one cycle of latency.
    logic [15:0] im_mem [DEPTH];
    logic [7:0]  dm_mem [DEPTH];
    int          wr_count = 0;

    always @(posedge clk) begin
        if (im_we) im_mem[mem_addr[11:0]] <= mem_wdata;
        if (dm_we) dm_mem[mem_addr[11:0]] <= mem_wdata[7:0];
        dm_rdata <= dm_mem[mem_addr[11:0]];
        if (im_we || dm_we) wr_count <= wr_count + 1;
    end

    // Reference images, filled from the commands the bench issues.
    logic [15:0] im_ref [DEPTH];
    logic [7:0]  dm_ref [DEPTH];
    bit          im_t   [DEPTH];
    bit          dm_t   [DEPTH];

    int checks = 0;
    int errors = 0;
    logic [15:0] beats[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, hif.cmd_ready, 0);
        check({tag, "_wr_ready"},  hif.wr_ready, 0);
        check({tag, "_rd_valid"},  hif.rd_valid, 0);
        check({tag, "_done"},      hif.done, 0);
        check({tag, "_err"},       hif.err, 0);
        check({tag, "_busy"},      hif.busy, 0);
        check({tag, "_we"},        {30'd0, im_we, dm_we}, 0);
        check({tag, "_cpu_run"},   cpu_run, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rd_data"},   hif.rd_data, 0);
    endtask

    task automatic issue(input logic [1:0] op, input int addr, input int len);
        @(negedge clk);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        hif.cmd_addr  = addr[15:0];
        hif.cmd_len   = len[15:0];
        for (int k = 0; k < 20 && !hif.cmd_ready; k++) @(negedge clk);
        check("cmd_ready", hif.cmd_ready, 1);
        @(posedge clk);
        #1;
        hif.cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] op, input int addr, input bit gaps);
        int len;
        bit exp_err;
        int wc0;
        len     = beats.size();
        exp_err = (addr + len > DEPTH);
        wc0     = wr_count;
        issue(op, addr, len);
        if (exp_err || len == 0) begin
            @(negedge clk);
            check("ld_done", hif.done, 1);
            check("ld_err", hif.err, exp_err);
            check("ld_busy", hif.busy, 0);
            check("ld_wr_ready", hif.wr_ready, 0);
            check("ld_nowrite", wr_count - wc0, 0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                hif.wr_valid = 1'b0;
                @(negedge clk);
                check("ld_gap_we", im_we | dm_we, 0);
                check("ld_gap_busy", hif.busy, 1);
                @(posedge clk);
                #1;
            end
            hif.wr_valid = 1'b1;
            hif.wr_data  = beats[i];
            @(negedge clk);
            check("ld_wr_ready", hif.wr_ready, 1);
            check("ld_im_we", im_we, op == OP_LOAD_IM);
            check("ld_dm_we", dm_we, op == OP_LOAD_DM);
            check("ld_addr", mem_addr, addr + i);
            check("ld_wdata", mem_wdata, beats[i]);
            check("ld_rd_valid", hif.rd_valid, 0);
            check("ld_done_early", hif.done, 0);
            if (op == OP_LOAD_IM) begin
                im_ref[addr + i] = beats[i];
                im_t[addr + i]   = 1'b1;
            end else begin
                dm_ref[addr + i] = beats[i][7:0];
                dm_t[addr + i]   = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        hif.wr_valid = 1'b0;
        @(negedge clk);
        check("ld_done", hif.done, 1);
        check("ld_err", hif.err, 0);
        check("ld_busy", hif.busy, 0);
        check("ld_wr_ready_end", hif.wr_ready, 0);
        check("ld_writes", wr_count - wc0, len);
    endtask

    task automatic read_dm(input int addr, input int len, input int stall_beat, input int stall_cyc);
        bit exp_err;
        int n;
        exp_err = (addr + len > DEPTH);
        issue(OP_READ_DM, addr, len);
        if (exp_err || len == 0) begin
            @(negedge clk);
            check("rd_done", hif.done, 1);
            check("rd_err", hif.err, exp_err);
            check("rd_valid_none", hif.rd_valid, 0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!hif.rd_valid && n < 10);
            check("rd_lat", n, 3);
            check("rd_valid", hif.rd_valid, 1);
            check("rd_data", hif.rd_data, dm_ref[addr + i]);
            check("rd_wr_ready", hif.wr_ready, 0);
            check("rd_busy", hif.busy, 1);
            if (i == stall_beat) begin
                repeat (stall_cyc) begin
                    @(negedge clk);
                    check("rd_hold_valid", hif.rd_valid, 1);
                    check("rd_hold_data", hif.rd_data, dm_ref[addr + i]);
                end
            end
            hif.rd_ready = 1'b1;
            @(posedge clk);
            #1;
            hif.rd_ready = 1'b0;
        end
        @(negedge clk);
        check("rd_done", hif.done, 1);
        check("rd_err", hif.err, 0);
        check("rd_valid_end", hif.rd_valid, 0);
        check("rd_busy_end", hif.busy, 0);
    endtask

    task automatic run(input int end_after);
        if (end_after == 0) cpu_end = 1'b1;
        issue(OP_RUN, 0, 0);
        @(negedge clk);
        check("run_cpu_run", cpu_run, 1);
        check("run_busy", hif.busy, 1);
        for (int k = 1; k < end_after; k++) begin
            @(negedge clk);
            check("run_hold", cpu_run, 1);
            check("run_done_early", hif.done, 0);
        end
        cpu_end = 1'b1;
        @(posedge clk);
        #1;
        cpu_end = 1'b0;
        @(negedge clk);
        check("run_stop", cpu_run, 0);
        check("run_done", hif.done, 1);
        check("run_err", hif.err, 0);
        check("run_busy_end", hif.busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int len, addr, n, bad, wc0;
        logic [1:0] op;

        hif.cmd_valid = 1'b0;
        hif.cmd_op    = 2'd0;
        hif.cmd_addr  = '0;
        hif.cmd_len   = '0;
        hif.wr_valid  = 1'b0;
        hif.wr_data   = '0;
        hif.rd_ready  = 1'b0;

        // Reset state and release.
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        #1;
        check("rst_release_cmd_ready", hif.cmd_ready, 1);

        // LOAD_IM 0x10 len 4, back-to-back beats.
        beats = {16'hA001, 16'hA002, 16'hA003, 16'hA004};
        load(OP_LOAD_IM, 'h10, 1'b0);
        @(negedge clk);
        check("done_pulse", hif.done, 0);

        // LOAD_DM overflowing the memory end; err stays until next accept.
        beats = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        load(OP_LOAD_DM, 'h0FFE, 1'b0);
        @(negedge clk);
        check("err_sticky", hif.err, 1);
        check("err_done_pulse", hif.done, 0);

        // RUN ending on cpu_end after 20 cycles; clears the sticky err.
        run(20);

        // READ_DM addr 5 len 3 with a 4-cycle stall on the second beat.
        beats = {16'h0011, 16'h0022, 16'h0033};
        load(OP_LOAD_DM, 5, 1'b0);
        read_dm(5, 3, 1, 4);

        // cpu_end already high when RUN starts.
        run(0);

        // Range boundaries: exact fit, one past, len 0 at and past the end.
        beats = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        load(OP_LOAD_IM, 4092, 1'b0);
        load(OP_LOAD_IM, 4093, 1'b0);
        read_dm(4095, 2, 0, 0);
        beats = {};
        load(OP_LOAD_DM, 4096, 1'b0);
        load(OP_LOAD_DM, 4097, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 10; it++) begin
            len  = $urandom_range(1, 6);
            op   = ($urandom_range(1) == 1) ? OP_LOAD_DM : OP_LOAD_IM;
            addr = ($urandom_range(3) == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4000);
            beats = {};
            for (int k = 0; k < len; k++) beats.push_back(16'($urandom));
            load(op, addr, 1'b1);
            if (op == OP_LOAD_DM) read_dm(addr, len, $urandom_range(0, len - 1), $urandom_range(0, 3));
            run($urandom_range(0, 4));
        end

`ifdef CPU_HOST_WDOG_EN
        // Watchdog: RUN with no cpu_end times out after 100 cycles.
        issue(OP_RUN, 0, 0);
        n = 0;
        @(negedge clk);
        while (cpu_run && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("wdog_cycles", n, 100);
        check("wdog_done", hif.done, 1);
        check("wdog_err", hif.err, 1);
        check("wdog_busy", hif.busy, 0);
`endif

        // Reset in the middle of a LOAD_IM after 2 of 5 beats.
        issue(OP_LOAD_IM, 'h100, 5);
        for (int i = 0; i < 2; i++) begin
            hif.wr_valid = 1'b1;
            hif.wr_data  = 16'hC000 + 16'(i);
            im_ref['h100 + i] = 16'hC000 + 16'(i);
            im_t['h100 + i]   = 1'b1;
            @(posedge clk);
            #1;
        end
        hif.wr_data = 16'hC002;
        @(negedge clk);
        check("mid_im_we", im_we, 1);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        hif.wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_cmd_ready", hif.cmd_ready, 1);
        check("partial_kept0", im_mem['h100], 16'hC000);
        check("partial_kept1", im_mem['h101], 16'hC001);
        wc0 = wr_count;
        beats = {};
        load(OP_LOAD_DM, 0, 1'b0);
        check("len0_no_write", wr_count - wc0, 0);

        // Final image comparison over every touched location.
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (im_t[a] && im_mem[a] !== im_ref[a]) bad++;
            if (dm_t[a] && dm_mem[a] !== dm_ref[a]) bad++;
        end
        check("mem_image", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_host_ctrl.md
# cpu_host_ctrl

Parametrised host-side controller for the processor subsystem: it loads instruction and data memory, launches execution and streams results back under valid/ready handshakes. It sits between an external host (UART/bus bridge) and the cpu top, which previously relied on a raw `status`/address/data interface. The controller adds command sequencing, bulk burst transfers, range checking and an optional run watchdog.

## Interface
- `DATA_W`, 8: data memory word width.
- `INSTR_W`, 16: instruction word width; host write beats are this wide.
- `ADDR_W`, 16: address width for both memories.
- `IM_DEPTH`, 4096: instruction memory words.
- `DM_DEPTH`, 4096: data memory words.
- `WDOG_CYCLES`, 65535: run timeout; used only with the watchdog macro.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`/`cmd_ready`, in/out, 1: command handshake.
- `cmd_op`, in, 2: 0 LOAD_IM, 1 LOAD_DM, 2 RUN, 3 READ_DM.
- `cmd_addr`, in, ADDR_W: start address.
- `cmd_len`, in, ADDR_W: beat count; 0 is legal.
- `wr_valid`/`wr_ready`, in/out, 1: load-data handshake.
- `wr_data`, in, INSTR_W: load beat; LOAD_DM uses `[DATA_W-1:0]`.
- `rd_valid`/`rd_ready`, out/in, 1: readback handshake.
- `rd_data`, out, DATA_W: readback beat.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err`, out, 1: sticky error; cleared when the next command is accepted.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `im_we`, `dm_we`, out, 1: memory write strobes.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_wdata`, out, INSTR_W: memory write data.
- `dm_rdata`, in, DATA_W: data memory read data; the memory is synchronous with 1-cycle latency.
- `cpu_run`, out, 1: processor enable, level.
- `cpu_end`, in, 1: processor end_process.

## Operation
- States: IDLE, LOAD, RUN, RD_REQ, RD_WAIT, RD_OUT.
- **IDLE**
  - `cmd_ready`=1; a command is accepted on `cmd_valid&&cmd_ready`.
  - `cmd_addr` and `cmd_len` are latched on acceptance.
  - `err` is cleared on acceptance.
- **Range check at accept** (loads and READ_DM)
  - Fail when `addr+len > DEPTH` of the target memory; the sum is computed ADDR_W+1 bits wide, so there is no wrap.
  - On failure: set `err`, pulse `done` next cycle, return to IDLE, no memory access.
- **len==0**: `done` pulses next cycle and nothing else happens.
- **LOAD**
  - `wr_ready`=1.
  - Each accepted beat asserts `im_we` or `dm_we` in the same cycle, with `mem_addr`=current address and `mem_wdata`=`wr_data`.
  - Address increments and remaining count decrements per beat.
  - After the last beat, `done` pulses and the FSM returns to IDLE.
- **RUN**
  - `cpu_run`=1 from the cycle after accept until `cpu_end` is sampled high.
  - Then `cpu_run`=0, `done` pulses, FSM returns to IDLE.
  - `cpu_end` already high at entry completes after 1 cycle in RUN.
- **READ_DM**
  - RD_REQ drives `mem_addr`.
  - RD_WAIT captures `dm_rdata` into the `rd_data` register.
  - RD_OUT holds `rd_valid`=1 until `rd_ready`, then moves to the next address (RD_REQ) or to `done`/IDLE.
  - `rd_data` is stable while `rd_valid` is high and not accepted.
- **Handshake scope**: `wr_ready`/`rd_valid` are never asserted outside their own command.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 in the first cycle after release. `wr_ready`, `rd_valid`, `done`, `err`, `busy`, `im_we`, `dm_we`, `cpu_run` all 0. `mem_addr`, `mem_wdata`, `rd_data` all 0.
- Load throughput: 1 beat/cycle.
- Readback throughput: 1 beat per 3 cycles with `rd_ready` held high. First `rd_valid` is 3 cycles after command accept.
- `done` is asserted 1 cycle after the final beat handshake or the `cpu_end` sample.
- Reset mid-operation:
  - All outputs return to reset values immediately (async).
  - `cpu_run` drops, so the processor halts.
  - Partial loads are not rolled back.

## Configuration
- `CPU_HOST_WDOG_EN` defined:
  - A cycle counter runs in RUN.
  - On reaching `WDOG_CYCLES` without `cpu_end`: drop `cpu_run`, set `err`, pulse `done`, return to IDLE.
- Undefined: no counter, and RUN waits indefinitely for `cpu_end`.

## Structure
- Shared package `cpu_host_pkg`:
  - opcode enum (`OP_LOAD_IM`, `OP_LOAD_DM`, `OP_RUN`, `OP_READ_DM`)
  - FSM state typedef
  - default width/depth constants
- Sub-module `host_range_check`: combinational overflow check of `addr+len` against depth. Instantiated once, with the depth muxed by opcode.

## Test plan
- LOAD_IM addr=0x0010 len=4, beats 0xA001..0xA004 back-to-back → `im_we` high 4 consecutive cycles at addresses 0x10..0x13, `done` the cycle after.
- LOAD_DM addr=0x0FFE len=4 with DM_DEPTH=4096 → no `dm_we`, `err`=1, `done` pulse.
- RUN with `cpu_end` asserted 20 cycles after `cpu_run` rises → `cpu_run` falls and `done` pulses; `err`=0.
- READ_DM addr=5 len=3, memory holding 0x11/0x22/0x33, `rd_ready` low for 4 cycles on the 2nd beat → values arrive in order and `rd_data`=0x22 is held stable while stalled.
- With `CPU_HOST_WDOG_EN` and `WDOG_CYCLES`=100, RUN with `cpu_end` never asserted → `cpu_run` drops after 100 cycles, `err`=1, `done` pulse.
- `rst` asserted mid-LOAD after 2 of 5 beats → all outputs 0 asynchronously; after release, `cmd_ready`=1 and a new LOAD_DM len=0 gives a `done` pulse with no writes.
